iir_coef_loader: RTL and testbench

Writer side of the IIR cascade's coefficient/scale memory. It accepts a framed stream of fixed-point words over a valid/ready handshake and fills a shadow bank. It commits the shadow bank atomically to the active bank on the next sample strobe (CE), so filter coefficients change only between samples. The active bank is a flat bus driven into the cascaded second-order sections.

---
 rtl/iir_pkg.sv | 29 ++
 rtl/iir_coef_bank.sv | 38 +++
 rtl/iir_coef_loader.sv | 134 +++++++++++++
 tb/tb_iir_coef_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants, loader state and default-word helpers for the IIR cascade
package iir_pkg;

   localparam int COEFS_PER_SOS = 6;
   localparam int IDX_SCALE     = 0;
   localparam int IDX_B0        = 1;
   localparam int IDX_B1        = 2;
   localparam int IDX_B2        = 3;
   localparam int IDX_A1        = 4;
   localparam int IDX_A2        = 5;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_LOAD        = 2'd1,
      ST_COMMIT_WAIT = 2'd2
   } load_state_t;

   function automatic logic [31:0] unity(input int wfs);
      return 32'd1 << wfs;
   endfunction

   // Pass-through section: scale = b0 = 1.0, all other taps zero.
   function automatic logic [31:0] default_word(input int i, input int wfs);
      int pos;
      pos = i % COEFS_PER_SOS;
      return (pos == IDX_SCALE || pos == IDX_B0) ? unity(wfs) : 32'd0;
   endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// rtl/iir_coef_bank.sv - shadow/active coefficient register pair with atomic commit
module iir_coef_bank
   import iir_pkg::*;
#(
   parameter int NW  = 24,
   parameter int W   = 16,
   parameter int WFS = 11,
   parameter int IW  = 5
) (
   input  logic              CLK,
   input  logic              nReset,
   input  logic              we,
   input  logic [IW-1:0]     addr,
   input  logic [W-1:0]      data,
   input  logic              commit_en,
   output logic [NW*W-1:0]   coef_active
);

   logic [W-1:0] shadow [NW];

   always_ff @(posedge CLK) begin
      if (!nReset) begin
         for (int i = 0; i < NW; i++) begin
            shadow[i]              <= '0;
            coef_active[i*W +: W]  <= W'(default_word(i, WFS));
         end
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (we && addr == IW'(i))
               shadow[i] <= data;
            // Whole bank moves in one edge so the filter never sees a partial set.
            if (commit_en)
               coef_active[i*W +: W] <= shadow[i];
         end
      end
   end

endmodule

// File: rtl/iir_coef_loader.sv
// rtl/iir_coef_loader.sv - framed coefficient stream loader; IIR_COEF_READBACK_EN adds a read port
module iir_coef_loader
   import iir_pkg::*;
#(
   parameter int NUMBER = 4,
   parameter int WIS    = 5,
   parameter int WFS    = 11,
   parameter int K      = COEFS_PER_SOS,
   localparam int W     = WIS + WFS,
   localparam int NW    = NUMBER * K,
   localparam int IW    = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic              CLK,
   input  logic              nReset,
   input  logic              CE,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [W-1:0]      s_data,
   input  logic              s_first,
   input  logic              s_last,
   output logic [NW*W-1:0]   coef_active,
   output logic              busy,
   output logic              commit,
   output logic              frame_err
`ifdef IIR_COEF_READBACK_EN
   ,
   input  logic              rd_en,
   input  logic [IW-1:0]     rd_addr,
   output logic [W-1:0]      rd_data
`endif
);

   load_state_t   state;
   logic [IW-1:0] idx;
   logic          xfer;
   logic [IW-1:0] word_pos;
   logic          at_end;
   logic          bank_we;
   logic          commit_en;

   always_comb begin
      xfer      = s_valid & s_ready;
      word_pos  = s_first ? '0 : idx;
      at_end    = (word_pos == IW'(NW - 1));
      bank_we   = xfer && (s_first || state == ST_LOAD);
      commit_en = (state == ST_COMMIT_WAIT) && CE;
   end

   always_ff @(posedge CLK) begin
      if (!nReset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         s_ready   <= 1'b1;
         busy      <= 1'b0;
         commit    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         commit    <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (xfer) begin
                  if (!s_first && state == ST_IDLE) begin
                     frame_err <= 1'b1;
                  end else if (s_last && at_end) begin
                     state   <= ST_COMMIT_WAIT;
                     s_ready <= 1'b0;
                     busy    <= 1'b1;
                  end else if (s_last || at_end) begin
                     // Short or long frame: drop it, active bank stays as it was.
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                     idx       <= '0;
                  end else begin
                     state <= ST_LOAD;
                     busy  <= 1'b1;
                     idx   <= word_pos + IW'(1);
                  end
               end
            end
            ST_COMMIT_WAIT: begin
               if (CE) begin
                  commit  <= 1'b1;
                  state   <= ST_IDLE;
                  s_ready <= 1'b1;
                  busy    <= 1'b0;
                  idx     <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               s_ready <= 1'b1;
               busy    <= 1'b0;
               idx     <= '0;
            end
         endcase
      end
   end

   iir_coef_bank #(
      .NW  (NW),
      .W   (W),
      .WFS (WFS),
      .IW  (IW)
   ) u_bank (
      .CLK         (CLK),
      .nReset      (nReset),
      .we          (bank_we),
      .addr        (word_pos),
      .data        (s_data),
      .commit_en   (commit_en),
      .coef_active (coef_active)
   );

`ifdef IIR_COEF_READBACK_EN
   logic [W-1:0] rd_next;

   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NW; i++)
         if (rd_addr == IW'(i))
            rd_next = coef_active[i*W +: W];
   end

   always_ff @(posedge CLK) begin
      if (!nReset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_next;
   end
`endif

endmodule

// File: tb/tb_iir_coef_loader.sv
// tb/tb_iir_coef_loader.sv - directed self-checking bench for iir_coef_loader
module tb_iir_coef_loader;

   logic         CLK = 1'b0;
   logic         nReset = 1'b0;
   logic         CE = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [15:0]  s_data = '0;
   logic         s_first = 1'b0;
   logic         s_last = 1'b0;
   logic [383:0] coef_active;
   logic         busy;
   logic         commit;
   logic         frame_err;

   int n_cmp = 0;
   int n_err = 0;

   iir_coef_loader dut (
      .CLK         (CLK),
      .nReset      (nReset),
      .CE          (CE),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_first     (s_first),
      .s_last      (s_last),
      .coef_active (coef_active),
      .busy        (busy),
      .commit      (commit),
      .frame_err   (frame_err)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [383:0] def_bank();
      logic [383:0] r;
      r = '0;
      for (int i = 0; i < 24; i++)
         if (i % 6 == 0 || i % 6 == 1)
            r[i*16 +: 16] = 16'h0800;
      return r;
   endfunction

   function automatic logic [383:0] seq(input logic [15:0] base);
      logic [383:0] r;
      for (int i = 0; i < 24; i++)
         r[i*16 +: 16] = base + 16'(i);
      return r;
   endfunction

   task automatic send(input logic [15:0] d, input logic f, input logic l);
      check("ready_before_send", {383'd0, s_ready}, 384'd1);
      s_valid = 1'b1; s_data = d; s_first = f; s_last = l;
      tick();
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] base, input int n, input logic last_flag);
      for (int i = 0; i < n; i++)
         send(base + 16'(i), i == 0, last_flag && (i == n - 1));
   endtask

   initial begin
      // Reset
      nReset = 1'b0;
      tick(); tick();
      nReset = 1'b1;
      tick();
      check("rst_active",    coef_active, def_bank());
      check("rst_ready",     {383'd0, s_ready},   384'd1);
      check("rst_busy",      {383'd0, busy},      384'd0);
      check("rst_commit",    {383'd0, commit},    384'd0);
      check("rst_frame_err", {383'd0, frame_err}, 384'd0);

      // Full frame held off by CE
      send_frame(16'h0001, 24, 1'b1);
      check("cw_ready",  {383'd0, s_ready}, 384'd0);
      check("cw_busy",   {383'd0, busy},    384'd1);
      check("cw_active", coef_active, def_bank());
      for (int i = 0; i < 10; i++) tick();
      check("cw_hold_active", coef_active, def_bank());
      check("cw_hold_commit", {383'd0, commit}, 384'd0);
      CE = 1'b1;
      tick();
      CE = 1'b0;
      check("full_commit", {383'd0, commit}, 384'd1);
      check("full_active", coef_active, seq(16'h0001));
      tick();
      check("full_commit_drop", {383'd0, commit}, 384'd0);
      check("full_idle_busy",   {383'd0, busy},   384'd0);
      check("full_idle_ready",  {383'd0, s_ready}, 384'd1);

      // Short frame
      send_frame(16'h0100, 10, 1'b1);
      check("short_err",    {383'd0, frame_err}, 384'd1);
      check("short_busy",   {383'd0, busy},      384'd0);
      check("short_active", coef_active, seq(16'h0001));
      CE = 1'b1;
      tick();
      check("short_err_drop", {383'd0, frame_err}, 384'd0);
      tick();
      CE = 1'b0;
      check("short_no_commit", {383'd0, commit}, 384'd0);
      check("short_active2",   coef_active, seq(16'h0001));

      // Stray word without s_first in IDLE
      send(16'h7777, 1'b0, 1'b0);
      check("stray_err",  {383'd0, frame_err}, 384'd1);
      check("stray_busy", {383'd0, busy},      384'd0);

      // Long frame, then restart mid-frame
      send_frame(16'h0200, 24, 1'b0);
      check("long_err",    {383'd0, frame_err}, 384'd1);
      check("long_busy",   {383'd0, busy},      384'd0);
      check("long_active", coef_active, seq(16'h0001));
      send_frame(16'h0300, 5, 1'b0);
      check("partial_busy", {383'd0, busy}, 384'd1);
      send(16'h0400, 1'b1, 1'b0);
      check("restart_no_err", {383'd0, frame_err}, 384'd0);
      check("restart_busy",   {383'd0, busy},      384'd1);
      for (int i = 1; i < 24; i++)
         send(16'h0400 + 16'(i), 1'b0, i == 23);
      check("restart_cw_ready", {383'd0, s_ready}, 384'd0);
      CE = 1'b1;
      tick();
      CE = 1'b0;
      check("restart_commit", {383'd0, commit}, 384'd1);
      check("restart_active", coef_active, seq(16'h0400));
      tick();

      // Gapped stream with CE held high
      CE = 1'b1;
      for (int i = 0; i < 24; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) tick();
         send(16'h0500 + 16'(i), i == 0, i == 23);
      end
      check("bp_cw_ready",  {383'd0, s_ready}, 384'd0);
      check("bp_no_commit", {383'd0, commit},  384'd0);
      s_valid = 1'b1; s_data = 16'hDEAD; s_first = 1'b0; s_last = 1'b0;
      tick();
      s_valid = 1'b0;
      check("bp_commit", {383'd0, commit}, 384'd1);
      check("bp_active", coef_active, seq(16'h0500));
      tick();
      CE = 1'b0;
      check("bp_junk_dropped", {383'd0, frame_err}, 384'd0);
      check("bp_commit_drop",  {383'd0, commit},    384'd0);

      // Reset during LOAD
      send_frame(16'h0600, 12, 1'b0);
      check("mid_load_busy", {383'd0, busy}, 384'd1);
      nReset = 1'b0;
      tick();
      nReset = 1'b1;
      check("rl_active", coef_active, def_bank());
      check("rl_busy",   {383'd0, busy},    384'd0);
      check("rl_ready",  {383'd0, s_ready}, 384'd1);

      // Reset during COMMIT_WAIT, with CE high on the reset edge
      send_frame(16'h0600, 24, 1'b1);
      check("rc_cw_busy", {383'd0, busy}, 384'd1);
      CE = 1'b1; nReset = 1'b0;
      tick();
      CE = 1'b0; nReset = 1'b1;
      check("rc_no_commit", {383'd0, commit}, 384'd0);
      check("rc_active",    coef_active, def_bank());
      tick();
      check("rc_no_commit2", {383'd0, commit}, 384'd0);
      check("rc_busy",       {383'd0, busy},   384'd0);

      // Clean reload after resets
      send_frame(16'h0700, 24, 1'b1);
      CE = 1'b1;
      tick();
      CE = 1'b0;
      check("reload_commit", {383'd0, commit}, 384'd1);
      check("reload_active", coef_active, seq(16'h0700));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
